counter_bank: RTL and testbench

COUNTER_BANK -- requirements
Module: counter_bank

---
 rtl/counter_bank.sv | 127 ++++++++++++
 tb/tb_counter_bank.sv | 138 +++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// Bank of independent up/down counters with per-channel clear, load and
// terminal-count pulse, gated by a post-reset hold sequence.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_HOLD | post-reset settling; hold timer counts down, counters held at 0
// ST_RUN  | ready asserted; channels respond to clr/load/en
module counter_bank #(
    parameter int    NUM_CH   = 4,
    parameter int    WIDTH    = 8,
    parameter string MODE     = "wrap",
    parameter int    RST_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       up_dn,
    input  logic [NUM_CH-1:0]       clr,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       tc,
    output logic                    ready
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $fatal(1, "counter_bank: NUM_CH must be 1..16");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "counter_bank: WIDTH must be 2..32");
    end
    if (RST_HOLD < 0 || RST_HOLD > 255) begin : g_bad_rst_hold
        $fatal(1, "counter_bank: RST_HOLD must be 0..255");
    end
    if (MODE != "wrap" && MODE != "saturate") begin : g_bad_mode
        $fatal(1, "counter_bank: MODE must be \"wrap\" or \"saturate\"");
    end

    localparam bit              SATURATE  = (MODE == "saturate");
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       HOLD_INIT = 8'(RST_HOLD);

    typedef enum logic {
        ST_HOLD,
        ST_RUN
    } state_t;

    state_t                         state_q,    state_d;
    logic [7:0]                     hold_cnt_q, hold_cnt_d;
    logic                           ready_q,    ready_d;
    logic [NUM_CH-1:0][WIDTH-1:0]   count_q,    count_d;
    logic [NUM_CH-1:0]              tc_q,       tc_d;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ready_d    = ready_q;
        count_d    = count_q;
        tc_d       = '0;
        case (state_q)
            ST_HOLD: begin
                count_d = '0;
                ready_d = 1'b0;
                if (hold_cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (clr[i]) begin
                        count_d[i] = '0;
                    end else if (load[i]) begin
                        count_d[i] = load_val[i*WIDTH +: WIDTH];
                    end else if (en[i]) begin
                        // A step past either end is the terminal event; saturate keeps the value.
                        if (up_dn[i]) begin
                            if (count_q[i] == CNT_MAX) begin
                                tc_d[i]    = 1'b1;
                                count_d[i] = SATURATE ? count_q[i] : '0;
                            end else begin
                                count_d[i] = count_q[i] + WIDTH'(1);
                            end
                        end else begin
                            if (count_q[i] == '0) begin
                                tc_d[i]    = 1'b1;
                                count_d[i] = SATURATE ? count_q[i] : CNT_MAX;
                            end else begin
                                count_d[i] = count_q[i] - WIDTH'(1);
                            end
                        end
                    end
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = HOLD_INIT;
                ready_d    = 1'b0;
                count_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= HOLD_INIT;
            ready_q    <= 1'b0;
            count_q    <= '0;
            tc_q       <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ready_q    <= ready_d;
            count_q    <= count_d;
            tc_q       <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank: a wrap and a saturate instance share
// stimulus; expected values are pushed per cycle and popped by a monitor.
module tb_counter_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en, up_dn, clr, load;
    logic [15:0] load_val;
    logic [15:0] count_w, count_s;
    logic [3:0]  tc_w, tc_s;
    logic        ready_w, ready_s;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [15:0] cw;
        logic [3:0]  tw;
        logic [15:0] cs;
        logic [3:0]  ts;
        logic        rdy;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    counter_bank #(.NUM_CH(4), .WIDTH(4), .MODE("wrap"), .RST_HOLD(3)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(count_w), .tc(tc_w), .ready(ready_w)
    );

    counter_bank #(.NUM_CH(4), .WIDTH(4), .MODE("saturate"), .RST_HOLD(3)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(count_s), .tc(tc_s), .ready(ready_s)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Monitor: one popped expectation per clock, sampled away from the rising edge.
    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({x.name, " ready_w"}, {15'd0, ready_w}, {15'd0, x.rdy});
            chk({x.name, " ready_s"}, {15'd0, ready_s}, {15'd0, x.rdy});
            chk({x.name, " count_w"}, count_w, x.cw);
            chk({x.name, " tc_w"},    {12'd0, tc_w}, {12'd0, x.tw});
            chk({x.name, " count_s"}, count_s, x.cs);
            chk({x.name, " tc_s"},    {12'd0, tc_s}, {12'd0, x.ts});
        end
    end

    task automatic drive(input logic r, input logic [3:0] e, input logic [3:0] u,
                         input logic [3:0] c, input logic [3:0] l, input logic [15:0] lv);
        @(negedge clk);
        #1;
        rst      = r;
        en       = e;
        up_dn    = u;
        clr      = c;
        load     = l;
        load_val = lv;
    endtask

    task automatic expect_out(input string nm, input logic [15:0] cw, input logic [3:0] tw,
                              input logic [15:0] cs, input logic [3:0] ts, input logic rdy);
        exp_t x;
        x.name = nm;
        x.cw   = cw;
        x.tw   = tw;
        x.cs   = cs;
        x.ts   = ts;
        x.rdy  = rdy;
        sb.push_back(x);
    endtask

    initial begin
        rst = 1'b1; en = '0; up_dn = '0; clr = '0; load = '0; load_val = '0;

        // reset dominates active enables, then hold for RST_HOLD+1 edges
        drive(1, 4'hF, 4'hF, 0, 0, 16'h0);     expect_out("rst_a",   16'h0000, 0, 16'h0000, 0, 0);
        drive(1, 4'hF, 4'hF, 0, 0, 16'h0);     expect_out("rst_b",   16'h0000, 0, 16'h0000, 0, 0);
        drive(0, 4'hF, 4'hF, 0, 0, 16'h0);     expect_out("hold_1",  16'h0000, 0, 16'h0000, 0, 0);
        drive(0, 4'hF, 4'hF, 0, 0, 16'h0);     expect_out("hold_2",  16'h0000, 0, 16'h0000, 0, 0);
        drive(0, 4'hF, 4'hF, 0, 0, 16'h0);     expect_out("hold_3",  16'h0000, 0, 16'h0000, 0, 0);
        drive(0, 4'hF, 4'hF, 0, 0, 16'h0);     expect_out("ready_up", 16'h0000, 0, 16'h0000, 0, 1);
        drive(0, 4'hF, 4'hF, 0, 0, 16'h0);     expect_out("run_1st", 16'h1111, 0, 16'h1111, 0, 1);

        // ch0 up through the top
        drive(0, 4'h0, 4'h0, 0, 4'h1, 16'h000E); expect_out("load_e",   16'h111E, 0, 16'h111E, 0, 1);
        drive(0, 4'h1, 4'h1, 0, 0, 16'h0);       expect_out("up_f",     16'h111F, 0, 16'h111F, 0, 1);
        drive(0, 4'h1, 4'h1, 0, 0, 16'h0);       expect_out("term_up",  16'h1110, 1, 16'h111F, 1, 1);
        drive(0, 4'h1, 4'h1, 0, 0, 16'h0);       expect_out("post_up",  16'h1111, 0, 16'h111F, 1, 1);

        // ch1 down through zero
        drive(0, 4'h0, 4'h0, 4'h1, 4'h2, 16'h0010); expect_out("load_1",  16'h1110, 0, 16'h1110, 0, 1);
        drive(0, 4'h2, 4'h0, 0, 0, 16'h0);          expect_out("dn_0",    16'h1100, 0, 16'h1100, 0, 1);
        drive(0, 4'h2, 4'h0, 0, 0, 16'h0);          expect_out("term_dn", 16'h11F0, 2, 16'h1100, 2, 1);
        drive(0, 4'h2, 4'h0, 0, 0, 16'h0);          expect_out("post_dn", 16'h11E0, 0, 16'h1100, 2, 1);

        // ch2 priority clr > load > en
        drive(0, 4'h4, 4'h4, 4'h6, 4'h4, 16'h0900); expect_out("prio_clr",  16'h1000, 0, 16'h1000, 0, 1);
        drive(0, 4'h4, 4'h4, 0, 4'h4, 16'h0900);    expect_out("prio_load", 16'h1900, 0, 16'h1900, 0, 1);

        // independence: ch0 up, ch1 down (terminal), ch2 load 5, ch3 idle
        drive(0, 4'h3, 4'h1, 0, 4'h4, 16'h0500);    expect_out("indep",     16'h15F1, 2, 16'h1501, 2, 1);
        drive(0, 4'h0, 4'h0, 0, 4'hF, 16'hF0F0);    expect_out("load_all",  16'hF0F0, 0, 16'hF0F0, 0, 1);
        drive(0, 4'hF, 4'hA, 0, 0, 16'h0);          expect_out("all_term",  16'h0F0F, 4'hF, 16'hF0F0, 4'hF, 1);

        // mid-operation reset discards the in-flight load and restarts hold
        drive(1, 4'hF, 4'hF, 0, 4'hF, 16'hFFFF);    expect_out("mid_rst",   16'h0000, 0, 16'h0000, 0, 0);
        drive(0, 4'hF, 4'hF, 0, 0, 16'h0);          expect_out("rhold_1",   16'h0000, 0, 16'h0000, 0, 0);
        drive(0, 4'hF, 4'hF, 0, 0, 16'h0);          expect_out("rhold_2",   16'h0000, 0, 16'h0000, 0, 0);
        drive(0, 4'hF, 4'hF, 0, 0, 16'h0);          expect_out("rhold_3",   16'h0000, 0, 16'h0000, 0, 0);
        drive(0, 4'hF, 4'hF, 0, 0, 16'h0);          expect_out("rready",    16'h0000, 0, 16'h0000, 0, 1);
        drive(0, 4'hF, 4'hF, 0, 0, 16'h0);          expect_out("resume",    16'h1111, 0, 16'h1111, 0, 1);
        drive(0, 4'h0, 4'h0, 0, 0, 16'h0);          expect_out("idle",      16'h1111, 0, 16'h1111, 0, 1);

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
